lcd_timing_gen: RTL and testbench



---
 rtl/lcd_timing_pkg.sv | 26 ++
 rtl/lcd_timing_gen_axis_counter.sv | 45 ++++
 rtl/lcd_timing_gen.sv | 111 +++++++++++
 tb/tb_lcd_timing_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared constants and types for the LCD video timing generator.
// Defaults describe the 800x480 panel; totals are a full line/frame period.
package lcd_timing_pkg;

    typedef logic [15:0] coord_t;

    localparam int MAX_TOTAL = 65535;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 210;
    localparam int DEF_H_SYNC   = 30;
    localparam int DEF_H_BP     = 16;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 22;
    localparam int DEF_V_SYNC   = 13;
    localparam int DEF_V_BP     = 10;

    function automatic int axis_total(input int sync_len, input int back_porch,
                                      input int active, input int front_porch);
        return sync_len + back_porch + active + front_porch;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);

endpackage

// File: rtl/lcd_timing_gen_axis_counter.sv
// Wrapping position counter for one video axis, with sync and active-window decode
// of both the current position and the position it will take on the next edge.
module timing_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int TOTAL     = DEF_H_TOTAL,
    parameter int SYNC      = DEF_H_SYNC,
    parameter int ACT_START = DEF_H_SYNC + DEF_H_BP,
    parameter int ACT_LEN   = DEF_H_ACTIVE
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   clear,
    input  logic   inc,
    output coord_t count,
    output logic   tc,
    output logic   in_sync,
    output logic   in_active,
    output logic   next_active
);

    localparam coord_t LAST     = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_END = coord_t'(SYNC);
    localparam coord_t ACT_LO   = coord_t'(ACT_START);
    localparam coord_t ACT_HI   = coord_t'(ACT_START + ACT_LEN);

    coord_t advanced;

    assign tc       = (count == LAST);
    assign advanced = inc ? (tc ? '0 : count + 16'd1) : count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else begin
            count <= advanced;
        end
    end

    // The look-ahead decode ignores clear: when clearing, the outputs are forced idle anyway.
    assign in_sync     = (count < SYNC_END);
    assign in_active   = (count >= ACT_LO) && (count < ACT_HI);
    assign next_active = (advanced >= ACT_LO) && (advanced < ACT_HI);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: registered HS/VS/DE, pixel coordinates, a one-cycle-early
// pixel request for the frame-buffer FIFO and a frame-start pulse.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic   CLK,
    input  logic   RESET_n,
    input  logic   EN,
    output logic   HS,
    output logic   VS,
    output logic   DE,
    output logic   REQ,
    output coord_t X,
    output coord_t Y,
    output logic   FRAME_START
);

    localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    localparam coord_t H_OFF = coord_t'(H_SYNC + H_BP);
    localparam coord_t V_OFF = coord_t'(V_SYNC + V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_params
        $error("lcd_timing_gen: line or frame total exceeds 16-bit counter range");
    end

    coord_t h;
    coord_t v;
    logic   h_tc;
    logic   v_tc;
    logic   h_sync;
    logic   v_sync;
    logic   h_act;
    logic   v_act;
    logic   h_next_act;
    logic   v_next_act;
    logic   idle;
    logic   act;
    logic   unused_v_tc;

    assign idle        = !EN;
    assign act         = h_act && v_act;
    assign unused_v_tc = v_tc;

    timing_axis_counter #(
        .TOTAL     (H_TOTAL),
        .SYNC      (H_SYNC),
        .ACT_START (H_SYNC + H_BP),
        .ACT_LEN   (H_ACTIVE)
    ) u_h_axis (
        .clk         (CLK),
        .reset_n     (RESET_n),
        .clear       (idle),
        .inc         (1'b1),
        .count       (h),
        .tc          (h_tc),
        .in_sync     (h_sync),
        .in_active   (h_act),
        .next_active (h_next_act)
    );

    timing_axis_counter #(
        .TOTAL     (V_TOTAL),
        .SYNC      (V_SYNC),
        .ACT_START (V_SYNC + V_BP),
        .ACT_LEN   (V_ACTIVE)
    ) u_v_axis (
        .clk         (CLK),
        .reset_n     (RESET_n),
        .clear       (idle),
        .inc         (h_tc),
        .count       (v),
        .tc          (v_tc),
        .in_sync     (v_sync),
        .in_active   (v_act),
        .next_active (v_next_act)
    );

    // Every pin is registered from the current counter position, so REQ decodes the
    // position one step ahead to land exactly one cycle before DE.
    always_ff @(posedge CLK) begin
        if (!RESET_n || !EN) begin
            HS          <= 1'b1;
            VS          <= 1'b1;
            DE          <= 1'b0;
            REQ         <= 1'b0;
            X           <= '0;
            Y           <= '0;
            FRAME_START <= 1'b0;
        end else begin
            HS          <= !h_sync;
            VS          <= !v_sync;
            DE          <= act;
            REQ         <= h_next_act && v_next_act;
            X           <= act ? (h - H_OFF) : '0;
            Y           <= act ? (v - V_OFF) : '0;
            FRAME_START <= (h == '0) && (v == '0);
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen using a linear frame-position reference model
// and randomized enable/reset activity on a small 10x6 timing set.
module tb_lcd_timing_gen;

    localparam int H_ACTIVE = 4;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 3;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int HT       = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT       = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int FT       = HT * VT;

    logic        CLK;
    logic        RESET_n;
    logic        EN;
    logic        HS;
    logic        VS;
    logic        DE;
    logic        REQ;
    logic [15:0] X;
    logic [15:0] Y;
    logic        FRAME_START;

    int checks;
    int errors;
    int pos;
    logic prev_req;
    int since_fs;
    int de_in_frame;
    bit seen_fs;
    bit interrupted;

    lcd_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) dut (
        .CLK         (CLK),
        .RESET_n     (RESET_n),
        .EN          (EN),
        .HS          (HS),
        .VS          (VS),
        .DE          (DE),
        .REQ         (REQ),
        .X           (X),
        .Y           (Y),
        .FRAME_START (FRAME_START)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit visibleAt(input int p);
        int hh;
        int vv;
        hh = p % HT;
        vv = p / HT;
        return (hh >= H_SYNC + H_BP) && (hh < H_SYNC + H_BP + H_ACTIVE) &&
               (vv >= V_SYNC + V_BP) && (vv < V_SYNC + V_BP + V_ACTIVE);
    endfunction

    // One clock of stimulus: drive on the falling edge, predict, then compare just after the rising edge.
    task automatic applyStimulus(input logic rst_n, input logic en);
        bit run;
        int hh, vv;
        int e_hs, e_vs, e_de, e_req, e_x, e_y, e_fs;
        @(negedge CLK);
        RESET_n = rst_n;
        EN      = en;
        run = rst_n && en;
        if (!run) begin
            e_hs = 1; e_vs = 1; e_de = 0; e_req = 0; e_x = 0; e_y = 0; e_fs = 0;
            pos = 0;
        end else begin
            hh    = pos % HT;
            vv    = pos / HT;
            e_hs  = (hh < H_SYNC) ? 0 : 1;
            e_vs  = (vv < V_SYNC) ? 0 : 1;
            e_de  = visibleAt(pos) ? 1 : 0;
            e_req = visibleAt((pos + 1) % FT) ? 1 : 0;
            e_x   = e_de ? hh - (H_SYNC + H_BP) : 0;
            e_y   = e_de ? vv - (V_SYNC + V_BP) : 0;
            e_fs  = (pos == 0) ? 1 : 0;
            pos   = (pos + 1) % FT;
        end
        @(posedge CLK);
        #1;
        checkOutput("HS", int'(HS), e_hs);
        checkOutput("VS", int'(VS), e_vs);
        checkOutput("DE", int'(DE), e_de);
        checkOutput("REQ", int'(REQ), e_req);
        checkOutput("X", int'(X), e_x);
        checkOutput("Y", int'(Y), e_y);
        checkOutput("FRAME_START", int'(FRAME_START), e_fs);
        if (run) begin
            checkOutput("req_leads_de", int'(prev_req), int'(DE));
            if (FRAME_START) begin
                if (seen_fs && !interrupted) begin
                    checkOutput("frame_period", since_fs, FT);
                    checkOutput("de_per_frame", de_in_frame, H_ACTIVE * V_ACTIVE);
                end
                seen_fs     = 1'b1;
                interrupted = 1'b0;
                since_fs    = 0;
                de_in_frame = 0;
            end
            since_fs++;
            de_in_frame += int'(DE);
        end else begin
            interrupted = 1'b1;
        end
        prev_req = REQ;
    endtask

    initial begin
        bit found;
        checks      = 0;
        errors      = 0;
        pos         = 0;
        prev_req    = 1'b0;
        since_fs    = 0;
        de_in_frame = 0;
        seen_fs     = 1'b0;
        interrupted = 1'b1;
        RESET_n     = 1'b0;
        EN          = 1'b0;

        repeat (3) applyStimulus(1'b0, 1'b1);
        repeat (130) applyStimulus(1'b1, 1'b1);

        // Abort mid-line while the pixel at X=2 is on the pins.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (DE && X == 16'd2) found = 1'b1;
        end
        checkOutput("reach_x2", int'(found), 1);
        repeat (5) applyStimulus(1'b1, 1'b0);
        repeat (130) applyStimulus(1'b1, 1'b1);

        repeat (13) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (130) applyStimulus(1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 29) != 0));
        end
        repeat (70) applyStimulus(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
